// File: rtl/sha256_padder_if.sv
// Byte-in / block-out bus between the host byte stream, the SHA-256 padder and the round pipeline.
// master drives the message bytes and accepts blocks; slave is the padder.
interface sha256_padder_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] out_block;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_block, out_valid, out_first, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_block, out_valid, out_first, out_last
    );
endinterface

// File: rtl/sha256_padder.sv
// Packs a byte stream into big-endian 512-bit SHA-256 blocks and appends FIPS 180-4 padding.
// state        | meaning
// FILL         | accepting bytes into the block buffer
// EMIT_DATA    | full data block presented, message may still need a padding block
// EMIT_PADONLY | data + 0x80 block presented, length block follows
// EMIT_FINAL   | block holding the length field presented, last of message
module sha256_padder #(
    parameter int LEN_WIDTH = 64
) (
    input logic            clk,
    input logic            rst_n,
    sha256_padder_if.slave bus
);
    typedef enum logic [1:0] {FILL, EMIT_DATA, EMIT_PADONLY, EMIT_FINAL} state_e;

    state_e               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [511:0]         buf_q, buf_d;
    logic                 first_q, first_d;
    logic                 pad_q, pad_d;

    logic                 accept;
    logic                 take;
    logic [63:0]          len_cur;
    logic [63:0]          len_next;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [8:0]           pos_cur;
    logic [8:0]           pos_nxt;

    assign bus.in_ready  = rst_n && (state_q == FILL);
    assign bus.out_valid = (state_q != FILL);
    assign bus.out_first = first_q && (state_q != FILL);
    assign bus.out_last  = (state_q == EMIT_FINAL);
    assign bus.out_block = buf_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign take     = bus.out_valid && bus.out_ready;
    assign cnt_inc  = cnt_q + LEN_WIDTH'(8);
    assign len_cur  = 64'(cnt_q);
    assign len_next = 64'(cnt_inc);
    // Top bit of byte idx and of byte idx+1 (the latter only used while idx < 63)
    assign pos_cur  = 9'd511 - {idx_q, 3'b000};
    assign pos_nxt  = pos_cur - 9'd8;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            first_q <= 1'b1;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            first_q <= first_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        first_d = first_q;
        pad_d   = pad_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d[pos_cur -: 8] = bus.in_data;
                    cnt_d = cnt_inc;
                    if (!bus.in_last) begin
                        if (idx_q == 6'd63) begin
                            idx_d   = '0;
                            state_d = EMIT_DATA;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end else if (idx_q == 6'd63) begin
                        pad_d   = 1'b1;
                        state_d = EMIT_DATA;
                    end else begin
                        // Unwritten bytes are already zero, so only the marker and length need placing
                        buf_d[pos_nxt -: 8] = 8'h80;
                        if (idx_q <= 6'd54) begin
                            buf_d[63:0] = len_next;
                            state_d     = EMIT_FINAL;
                        end else begin
                            state_d = EMIT_PADONLY;
                        end
                    end
                end
            end
            EMIT_DATA: begin
                if (take) begin
                    first_d = 1'b0;
                    if (pad_q) begin
                        buf_d   = {8'h80, 440'd0, len_cur};
                        pad_d   = 1'b0;
                        state_d = EMIT_FINAL;
                    end else begin
                        buf_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            EMIT_PADONLY: begin
                if (take) begin
                    first_d = 1'b0;
                    buf_d   = {448'd0, len_cur};
                    state_d = EMIT_FINAL;
                end
            end
            EMIT_FINAL: begin
                if (take) begin
                    buf_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end
endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: table of messages with a reference padding model
// feeding a block scoreboard, plus stall and mid-message reset sequences.
module tb_sha256_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_padder_if bus ();

    sha256_padder #(.LEN_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    typedef struct {
        int          len;
        logic [7:0]  start;
        logic [7:0]  step;
        int          nblocks;
        logic [63:0] lenfield;
    } vec_t;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           blocks_seen = 0;
    logic [511:0] last_blk = '0;
    logic [63:0]  last_len = '0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic void model(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        exp_t        e;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = p[64*b+j];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Scoreboard: one pop per handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            blocks_seen++;
            last_blk = bus.out_block;
            if (bus.out_last) last_len = bus.out_block[63:0];
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_block: got %0h required none", bus.out_block);
            end else begin
                e = exp_q.pop_front();
                check("block", bus.out_block, e.blk);
                check("out_first", 512'(bus.out_first), 512'(e.first));
                check("out_last", 512'(bus.out_last), 512'(e.last));
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 required 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit complete);
        if (complete) model(msg);
        for (int i = 0; i < msg.size(); i++)
            send_byte(msg[i], complete && (i == msg.size() - 1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending blocks required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish required finish before 5ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[10];
        logic [7:0] msg[$];
        logic [7:0] abc[$];
        logic [7:0] m64[$];
        int         bs;

        vecs[0] = '{3,   8'h61, 8'h01, 1, 64'h18};
        vecs[1] = '{55,  8'h00, 8'h00, 1, 64'h1B8};
        vecs[2] = '{56,  8'hFF, 8'h00, 2, 64'h1C0};
        vecs[3] = '{64,  8'h5A, 8'h00, 2, 64'h200};
        vecs[4] = '{3,   8'h61, 8'h01, 1, 64'h18};
        vecs[5] = '{1,   8'h11, 8'h00, 1, 64'h8};
        vecs[6] = '{63,  8'h00, 8'h01, 2, 64'h1F8};
        vecs[7] = '{119, 8'h10, 8'h03, 2, 64'h3B8};
        vecs[8] = '{120, 8'h20, 8'h05, 3, 64'h3C0};
        vecs[9] = '{128, 8'h01, 8'h07, 3, 64'h400};

        abc = '{8'h61, 8'h62, 8'h63};
        for (int i = 0; i < 64; i++) m64.push_back(8'h5A);

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 512'(bus.in_ready), 512'(0));
        check("reset_out_valid", 512'(bus.out_valid), 512'(0));
        check("reset_out_block", bus.out_block, 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 512'(bus.in_ready), 512'(1));
        check("out_first_idle", 512'(bus.out_first), 512'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            msg.delete();
            for (int j = 0; j < vecs[i].len; j++)
                msg.push_back(8'(int'(vecs[i].start) + int'(vecs[i].step) * j));
            bs = blocks_seen;
            send_msg(msg, 1'b1);
            drain();
            check("nblocks", 512'(blocks_seen - bs), 512'(vecs[i].nblocks));
            check("length_field", 512'(last_len), 512'(vecs[i].lenfield));
            if (vecs[i].len == 3 && vecs[i].start == 8'h61)
                check("abc_block", last_blk, ABC_BLK);
        end

        // Stall at block1 of the 64-byte message while the next message waits on in_valid
        bus.out_ready = 1'b0;
        bs = blocks_seen;
        fork
            begin
                send_msg(m64, 1'b1);
                send_msg(abc, 1'b1);
            end
            begin
                int           t;
                logic [511:0] held;
                t = 0;
                while (!bus.out_valid && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                held = bus.out_block;
                check("stall_block1", held, {64{8'h5A}});
                repeat (10) begin
                    @(negedge clk);
                    check("stall_hold", bus.out_block, held);
                    check("stall_in_ready", 512'(bus.in_ready), 512'(0));
                    check("stall_valid", 512'(bus.out_valid), 512'(1));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_nblocks", 512'(blocks_seen - bs), 512'(3));
        check("stall_abc_block", last_blk, ABC_BLK);

        // Abort a partial message with reset, then a fresh message must look untouched
        for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", 512'(bus.in_ready), 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 512'(bus.out_valid), 512'(0));
        check("midreset_buffer", bus.out_block, 512'(0));
        @(posedge clk);
        #1;
        bs = blocks_seen;
        send_msg(abc, 1'b1);
        drain();
        check("reset_abc_nblocks", 512'(blocks_seen - bs), 512'(1));
        check("reset_abc_block", last_blk, ABC_BLK);
        check("scoreboard_empty", 512'(exp_q.size()), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Producer side of the 512-bit message-block interface consumed by the SHA-256 round pipeline.
- Accepts a byte stream with valid/ready/last, builds big-endian 512-bit blocks, and applies FIPS 180-4 padding: 0x80 byte, zero fill, then the 64-bit message bit length.
- Emits blocks with valid/ready, plus first/last markers so downstream can load the IV and take the final digest.
- Sits between the host byte interface and the round pipeline input.

Parameters:
LEN_WIDTH, 64, width of internal bit-length counter (1..64); zero-extended to 64 bits in the length field; wraps modulo 2^LEN_WIDTH.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_data  input  8  message byte
in_valid  input  1  in_data valid
in_last  input  1  in_data is final byte of message (messages are >=1 byte)
in_ready  output  1  byte accepted when in_valid & in_ready
out_block  output  512  padded block; byte 0 of block at [511:504], so W0 = [511:480] and W15 = [31:0]
out_valid  output  1  out_block valid
out_first  output  1  block is first block of its message (qualified by out_valid)
out_last  output  1  block is final block of its message (qualified by out_valid)
out_ready  input  1  block taken when out_valid & out_ready

Behaviour:
- Reset (rst_n=0 at posedge): state=FILL, byte index=0, bit count=0, block buffer=0, first_pending=1, pad_pending=0, out_valid=0, out_first=0, out_last=0. in_ready=0 while rst_n=0 and =1 in the first cycle after release.
- in_ready=1 iff state==FILL (and rst_n=1). out_valid=1 iff state is an EMIT_* state. out_block is the buffer register; it is stable while out_valid=1 and out_ready=0.
- FILL, byte accepted at index k (0..63):
  - buf[k]=in_data; bitcount += 8.
  - in_last=0: if k==63, idx=0 and go to EMIT_DATA; else idx=k+1.
  - in_last=1, k==63: set pad_pending; go to EMIT_DATA.
  - in_last=1, k<=54: buf[k+1]=0x80, bytes k+2..55 zero, bytes 56..63 = 64-bit length (count including this byte); go to EMIT_FINAL.
  - in_last=1, 55<=k<=62: buf[k+1]=0x80, remaining bytes zero; go to EMIT_PADONLY.
- EMIT_DATA (out_last=0) on handshake:
  - If pad_pending: buf = {0x80, 55 zero bytes, length}; clear pad_pending; go to EMIT_FINAL.
  - Else clear buf, go to FILL.
- EMIT_PADONLY (out_last=0) on handshake: buf = {56 zero bytes, length}; go to EMIT_FINAL.
- EMIT_FINAL (out_last=1) on handshake: clear buf, idx, and bitcount; set first_pending=1; go to FILL.
- out_first = first_pending during any EMIT state. first_pending clears on the first block handshake of each message.
- Buffer bytes not yet written in FILL are zero, because the buffer is cleared on every transition back to FILL.
- Latency: block presented on the cycle after the accepting edge of byte 63 or the last byte. Peak throughput is 65 cycles per 64-byte data block.
- Back-pressure: no byte is accepted in any EMIT state; out_block, out_first, and out_last are held until the handshake.
- Reset mid-message or mid-emit discards all partial state. The next byte starts a new message with out_first=1.
- in_data and in_last are ignored when in_valid=0.

Test Plan:
- "abc" (0x61,0x62,0x63 last), out_ready=1 -> one block 0x61626380_00…00_00000000_00000018, out_first=1, out_last=1.
- 55 bytes 0x00, last on byte 54 -> one block: byte55=0x80, length field 0x1B8, first=1, last=1.
- 56 bytes 0xFF -> block1: bytes 0..55=0xFF, byte56=0x80, rest 0, first=1, last=0. Block2: 56 zero bytes + 0x1C0, first=0, last=1.
- 64 bytes 0x5A -> block1: all 0x5A, first=1, last=0. Block2: 0x80, zeros, 0x200, last=1. Then a second message "abc" -> first=1 and length 0x18 (counter cleared).
- Hold out_ready=0 for 10 cycles at block1 of the 64-byte case with in_valid=1 -> out_block constant, in_ready=0, no bytes lost. Output after release matches the unstalled run.
- Send 20 bytes, pull rst_n low 1 cycle, then send "abc" -> output identical to the first scenario. No stale data appears in out_block.
